// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin over active-low REQ#, registered one-hot-low GNT#,
// hidden arbitration, bus parking and a dead-master idle timeout.
module pci_bus_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter bit          PARK_EN      = 1'b1,
  parameter int unsigned PARK_AGENT   = 0,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame,
  input  logic             irdy,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [IW-1:0] ParkIdx    = IW'(PARK_AGENT);
  localparam logic [IW-1:0] LastIdx    = IW'(N_REQ - 1);
  localparam logic [TW-1:0] TimeoutVal = TW'(IDLE_TIMEOUT);

  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    last_owner_q, last_owner_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             idle_q;

  logic             bus_idle;
  logic             frame_start;
  logic             cur_valid;
  logic [IW-1:0]    cur_idx;
  logic             win_valid;
  logic [IW-1:0]    win_idx;
  logic             tgt_valid;
  logic [IW-1:0]    tgt_idx;
  logic [N_REQ-1:0] tgt_oh;
  logic             parked;
  logic             other_req;
  logic             timeout;

  assign bus_idle    = frame & irdy;
  // Address phase begins: bus was idle last clock and FRAME# is now asserted.
  assign frame_start = idle_q & ~frame;
  assign gnt         = gnt_q;

  // Locate the agent currently holding GNT# (at most one bit low).
  always_comb begin
    cur_valid = 1'b0;
    cur_idx   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!gnt_q[i]) begin
        cur_valid = 1'b1;
        cur_idx   = IW'(i);
      end
    end
  end

  // Round-robin winner: first registered request after last_owner, wrapping.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      logic [IW-1:0] cand;
      cand = IW'((32'(last_owner_q) + k) % N_REQ);
      if (!win_valid && req_q[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Target owner, timeout detection and next grant with a mandatory all-high gap.
  always_comb begin
    tgt_valid = 1'b0;
    tgt_idx   = '0;
    if (win_valid) begin
      tgt_valid = 1'b1;
      tgt_idx   = win_idx;
    end else if (PARK_EN) begin
      tgt_valid = 1'b1;
      tgt_idx   = ParkIdx;
    end

    tgt_oh          = '0;
    tgt_oh[tgt_idx] = 1'b1;

    // A parked grant is one held by the park agent without it requesting.
    parked    = PARK_EN && cur_valid && (cur_idx == ParkIdx) && !req_q[ParkIdx];
    other_req = |(req_q & gnt_q);
    timeout   = cur_valid && !parked && (timer_q >= TimeoutVal) && other_req;

    gnt_d = '1;
    if (timeout) begin
      gnt_d = '1;
    end else if (cur_valid) begin
      // Keep only if the same agent still wins; otherwise drop for one clock.
      gnt_d = (tgt_valid && tgt_idx == cur_idx) ? gnt_q : '1;
    end else if (tgt_valid) begin
      gnt_d = ~tgt_oh;
    end
  end

  // Ownership tracking and idle timer next state.
  always_comb begin
    last_owner_d = last_owner_q;
    if ((frame_start || timeout) && cur_valid) begin
      last_owner_d = cur_idx;
    end

    timer_d = timer_q;
    if (!frame || !cur_valid || parked || (gnt_d != gnt_q)) begin
      timer_d = '0;
    end else if (bus_idle && timer_q < TimeoutVal) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // State registers; reset forces all GNT# high immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q        <= '0;
      gnt_q        <= '1;
      last_owner_q <= LastIdx;
      timer_q      <= '0;
      idle_q       <= 1'b1;
    end else begin
      req_q        <= ~req;
      gnt_q        <= gnt_d;
      last_owner_q <= last_owner_d;
      timer_q      <= timer_d;
      idle_q       <= bus_idle;
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter: vector table for parking and alternation,
// hand sequences for hidden arbitration, idle timeout and asynchronous reset.
module tb_pci_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame = 1'b1;
  logic       irdy = 1'b1;
  logic [3:0] req = 4'b1111;
  logic [3:0] gnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] req;
    logic       frame;
    logic       irdy;
    logic [3:0] exp_gnt;
  } vec_t;

  vec_t vecs[19];

  pci_bus_arbiter #(
    .N_REQ       (4),
    .PARK_EN     (1'b1),
    .PARK_AGENT  (0),
    .IDLE_TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .frame(frame),
    .irdy (irdy),
    .req  (req),
    .gnt  (gnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: gnt=%b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic f, input logic i);
    req   = r;
    frame = f;
    irdy  = i;
  endtask

  task automatic do_reset();
    drive(4'b1111, 1'b1, 1'b1);
    reset = 1'b1;
    #3;
    check("reset_hold", gnt, 4'b1111);
    tick();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    // Park on agent 0, agent 1 takes the bus, then agents 0 and 1 alternate.
    vecs[0]  = '{4'b1111, 1'b1, 1'b1, 4'b1110};
    vecs[1]  = '{4'b1101, 1'b1, 1'b1, 4'b1110};
    vecs[2]  = '{4'b1101, 1'b1, 1'b1, 4'b1111};
    vecs[3]  = '{4'b1101, 1'b1, 1'b1, 4'b1101};
    vecs[4]  = '{4'b1111, 1'b0, 1'b1, 4'b1101};
    vecs[5]  = '{4'b1111, 1'b0, 1'b0, 4'b1111};
    vecs[6]  = '{4'b1111, 1'b1, 1'b0, 4'b1110};
    vecs[7]  = '{4'b1111, 1'b1, 1'b1, 4'b1110};
    vecs[8]  = '{4'b1100, 1'b1, 1'b1, 4'b1110};
    vecs[9]  = '{4'b1100, 1'b1, 1'b1, 4'b1110};
    vecs[10] = '{4'b1100, 1'b0, 1'b1, 4'b1110};
    vecs[11] = '{4'b1100, 1'b0, 1'b0, 4'b1111};
    vecs[12] = '{4'b1100, 1'b1, 1'b0, 4'b1101};
    vecs[13] = '{4'b1100, 1'b1, 1'b1, 4'b1101};
    vecs[14] = '{4'b1100, 1'b0, 1'b1, 4'b1101};
    vecs[15] = '{4'b1100, 1'b0, 1'b0, 4'b1111};
    vecs[16] = '{4'b1100, 1'b1, 1'b0, 4'b1110};
    vecs[17] = '{4'b1100, 1'b1, 1'b1, 4'b1110};
    vecs[18] = '{4'b1111, 1'b1, 1'b1, 4'b1110};

    #1;
    reset = 1'b1;
    #3;
    check("reset_async", gnt, 4'b1111);
    #4;
    reset = 1'b0;

    for (int v = 0; v < 19; v++) begin
      drive(vecs[v].req, vecs[v].frame, vecs[v].irdy);
      tick();
      check($sformatf("vec%0d", v), gnt, vecs[v].exp_gnt);
    end

    // Hidden arbitration: agent 2 is granted while agent 1's burst is still running.
    do_reset();
    drive(4'b1101, 1'b1, 1'b1);
    tick(); check("h_park", gnt, 4'b1110);
    tick(); check("h_gap0", gnt, 4'b1111);
    tick(); check("h_gnt1", gnt, 4'b1101);
    drive(4'b1011, 1'b0, 1'b1);
    tick(); check("h_addr1", gnt, 4'b1101);
    drive(4'b1011, 1'b0, 1'b0);
    tick(); check("h_gap1", gnt, 4'b1111);
    tick(); check("h_gnt2_framelow", gnt, 4'b1011);
    check("h_frame_still_low", {3'b000, frame}, 4'b0000);
    drive(4'b1011, 1'b1, 1'b0);
    tick(); check("h_last_data", gnt, 4'b1011);
    drive(4'b1011, 1'b1, 1'b1);
    tick(); check("h_idle", gnt, 4'b1011);

    // Agent 2 runs a burst, then agent 3 is granted but never starts; agent 1 waits.
    drive(4'b0101, 1'b0, 1'b1);
    tick(); check("t_addr2", gnt, 4'b1011);
    drive(4'b0101, 1'b1, 1'b0);
    tick(); check("t_gap", gnt, 4'b1111);
    drive(4'b0101, 1'b1, 1'b1);
    tick(); check("t_gnt3", gnt, 4'b0111);
    for (int c = 0; c < 16; c++) begin
      tick();
      check($sformatf("t_hold%0d", c), gnt, 4'b0111);
    end
    tick(); check("t_revoke", gnt, 4'b1111);
    tick(); check("t_gnt1", gnt, 4'b1101);

    // Reset mid-transaction must clear the grant without waiting for a clock edge.
    drive(4'b0101, 1'b0, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check("r_async_mid", gnt, 4'b1111);
    #3;
    drive(4'b1111, 1'b1, 1'b1);
    reset = 1'b0;
    tick(); check("r_repark", gnt, 4'b1110);

    // After reset, last_owner is agent 3 so agent 0 beats agent 2.
    drive(4'b1010, 1'b1, 1'b1);
    tick(); check("r_rr0_hold", gnt, 4'b1110);
    tick(); check("r_rr0_keep", gnt, 4'b1110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
